mult_accum_8b: RTL

MULT_ACCUM_8B -- requirements
Module: mult_accum_8b

---
 rtl/mult_accum_8b.sv | 106 ++++++++++
 1 files changed

// File: rtl/mult_accum_8b.sv
// Frame accumulator for the 16-bit multiplier product bus.
// Sums a framed sequence of products under a valid/ready handshake,
// saturating at the accumulator width and flagging overflow per frame.
module mult_accum_8b #(
    parameter int unsigned ACC_W = 20,
    parameter int unsigned LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic             in_valid,
    input  logic [15:0]      prod,
    output logic             in_ready,
    output logic [ACC_W-1:0] acc_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             overflow
);

    localparam logic [ACC_W-1:0] ACC_MAX = '1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic             ovf_q, ovf_d;

    // One extra bit on the sum exposes the carry used for saturation;
    // one extra bit on the count keeps len = 2^LEN_W-1 from wrapping.
    logic [ACC_W:0]   sum_c;
    logic [LEN_W:0]   cnt_inc_c;

    // Next-state, accumulate and saturate logic
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        len_d     = len_q;
        ovf_d     = ovf_q;
        sum_c     = {1'b0, acc_q} + (ACC_W + 1)'(prod);
        cnt_inc_c = {1'b0, cnt_q} + (LEN_W + 1)'(1);

        case (state_q)
            IDLE: begin
                if (start) begin
                    len_d   = len;
                    acc_d   = '0;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                    state_d = (len == '0) ? HOLD : ACCUM;
                end
            end
            ACCUM: begin
                if (in_valid) begin
                    acc_d = sum_c[ACC_W] ? ACC_MAX : sum_c[ACC_W-1:0];
                    ovf_d = ovf_q | sum_c[ACC_W];
                    cnt_d = cnt_inc_c[LEN_W-1:0];
                    if (cnt_inc_c == {1'b0, len_q}) begin
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            len_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            ovf_q   <= ovf_d;
        end
    end

    // Outputs decode directly from registered state
    assign in_ready  = (state_q == ACCUM);
    assign out_valid = (state_q == HOLD);
    assign busy      = (state_q != IDLE);
    assign acc_out   = acc_q;
    assign overflow  = ovf_q;

endmodule
